fir_xifu_offload: RTL and testbench

- Core-side initiator of the XIF issue/commit protocol that the FIR XIFU decode stage responds to.
- Buffers instructions from an upstream source in a small FIFO and drives them one at a time on the issue channel, holding each request stable until the coprocessor is ready.
- Samples the issue response, then sends a commit (or kill) for every issued ID.
- Used as the core-model front end in the XIFU subsystem and as the protocol reference for bring-up.

---
 rtl/fir_xifu_offload.sv | 102 ++++++++++
 tb/tb_fir_xifu_offload.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_offload.sv
// fir_xifu_offload: core-side XIF initiator. It buffers instructions in a FIFO, issues them one at a time,
// and sends exactly one in-order commit (or kill) for every issue handshake.
module fir_xifu_offload #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [31:0]     rs0_i,
    input  logic [31:0]     rs1_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [31:0]     issue_instr_o,
    output logic [31:0]     issue_rs0_o,
    output logic [31:0]     issue_rs1_o,
    output logic [ID_W-1:0] issue_id_o,
    input  logic            issue_accept_i,
    input  logic            issue_writeback_i,
    input  logic            issue_loadstore_i,
    output logic            commit_valid_o,
    output logic [ID_W-1:0] commit_id_o,
    output logic            commit_kill_o,
    output logic            resp_valid_o,
    output logic            resp_accept_o,
    output logic            resp_writeback_o,
    output logic            resp_loadstore_o,
    output logic [ID_W-1:0] resp_id_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;
    state_t state, state_nx;
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_rs0 [DEPTH];
    logic [31:0] mem_rs1 [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nx;
    logic [ID_W-1:0] id_cnt, rid_q;
    logic acc_q, wb_q, ls_q, kill_q;
    logic push, hs;
    assign instr_ready_o = count != (AW+1)'(DEPTH);
    assign push = instr_valid_i & instr_ready_o & ~clear_i;
    assign hs = issue_valid_o & issue_ready_i;
    always_comb count_nx = clear_i ? '0 : count + (AW+1)'(push) - (AW+1)'(hs);
    // Leaving IDLE/COMMIT looks at the post-update count so a push is issued the very next cycle.
    always_comb state_nx = (state == ISSUE) ? (hs ? COMMIT : clear_i ? IDLE : ISSUE)
                                            : (count_nx != '0 ? ISSUE : IDLE);
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[wr_ptr] <= instr_i;
            mem_rs0[wr_ptr]   <= rs0_i;
            mem_rs1[wr_ptr]   <= rs1_i;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            issue_valid_o  <= 1'b0;
            commit_valid_o <= 1'b0;
            resp_valid_o   <= 1'b0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            id_cnt         <= '0;
            rid_q          <= '0;
            acc_q          <= 1'b0;
            wb_q           <= 1'b0;
            ls_q           <= 1'b0;
            kill_q         <= 1'b0;
        end else begin
            state          <= state_nx;
            issue_valid_o  <= state_nx == ISSUE;
            commit_valid_o <= state_nx == COMMIT;
            resp_valid_o   <= state_nx == COMMIT;
            count          <= count_nx;
            wr_ptr         <= clear_i ? '0 : wr_ptr + AW'(push);
            rd_ptr         <= clear_i ? '0 : rd_ptr + AW'(hs);
            if (hs) begin
                id_cnt <= id_cnt + ID_W'(1);
                rid_q  <= id_cnt;
                acc_q  <= issue_accept_i;
                wb_q   <= issue_writeback_i;
                ls_q   <= issue_loadstore_i;
                kill_q <= clear_i;
            end
        end
    end
    assign issue_instr_o    = issue_valid_o ? mem_instr[rd_ptr] : '0;
    assign issue_rs0_o      = issue_valid_o ? mem_rs0[rd_ptr] : '0;
    assign issue_rs1_o      = issue_valid_o ? mem_rs1[rd_ptr] : '0;
    assign issue_id_o       = issue_valid_o ? id_cnt : '0;
    // A flush during the commit cycle still emits the commit, but as a kill.
    assign commit_id_o      = commit_valid_o ? rid_q : '0;
    assign commit_kill_o    = commit_valid_o & (~acc_q | kill_q | clear_i);
    assign resp_accept_o    = acc_q;
    assign resp_writeback_o = wb_q;
    assign resp_loadstore_o = ls_q;
    assign resp_id_o        = rid_q;
endmodule

// File: tb/tb_fir_xifu_offload.sv
// tb_fir_xifu_offload: directed protocol scenarios plus random traffic, checked every cycle
// against a transaction-level model (instruction queue, ID counter, pending commit).
module tb_fir_xifu_offload;
    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    logic clk_i = 0, rst_i = 1, clear_i = 0, instr_valid_i = 0, issue_ready_i = 0;
    logic issue_accept_i = 0, issue_writeback_i = 0, issue_loadstore_i = 0;
    logic [31:0] instr_i = 0, rs0_i = 0, rs1_i = 0;
    logic instr_ready_o, issue_valid_o, commit_valid_o, commit_kill_o;
    logic resp_valid_o, resp_accept_o, resp_writeback_o, resp_loadstore_o;
    logic [31:0] issue_instr_o, issue_rs0_o, issue_rs1_o;
    logic [ID_W-1:0] issue_id_o, commit_id_o, resp_id_o;
    int n_chk = 0, n_err = 0;
    always #5 clk_i = ~clk_i;
    fir_xifu_offload #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .rs0_i(rs0_i), .rs1_i(rs1_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
        .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i),
        .issue_writeback_i(issue_writeback_i), .issue_loadstore_i(issue_loadstore_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .resp_valid_o(resp_valid_o), .resp_accept_o(resp_accept_o),
        .resp_writeback_o(resp_writeback_o), .resp_loadstore_o(resp_loadstore_o),
        .resp_id_o(resp_id_o)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    task automatic push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr_valid_i = 1;
        instr_i = i;
        rs0_i = a;
        rs1_i = b;
        tick();
        instr_valid_i = 0;
    endtask
    task automatic do_reset();
        instr_valid_i = 0;
        clear_i = 0;
        rst_i = 1;
        repeat (2) tick();
        rst_i = 0;
    endtask
    typedef struct packed {logic [31:0] i; logic [31:0] a; logic [31:0] b;} ent_t;
    ent_t q[$];
    logic [ID_W-1:0] exp_id, cm_id;
    bit exp_iv, cm_pend, cm_acc, cm_wb, cm_ls, cm_kill;
    // Reference model: one step per cycle, sampled at the falling edge.
    always @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
            exp_id = '0;
            exp_iv = 0;
            cm_pend = 0;
        end else begin
            bit hs, full_now;
            full_now = q.size() >= DEPTH;
            chk("issue_valid", 32'(issue_valid_o), 32'(exp_iv));
            chk("instr_ready", 32'(instr_ready_o), 32'(!full_now));
            if (cm_pend) begin
                chk("commit_valid", 32'(commit_valid_o), 32'd1);
                chk("commit_id", 32'(commit_id_o), 32'(cm_id));
                chk("commit_kill", 32'(commit_kill_o), 32'(cm_kill | clear_i));
                chk("resp_valid", 32'(resp_valid_o), 32'd1);
                chk("resp_accept", 32'(resp_accept_o), 32'(cm_acc));
                chk("resp_writeback", 32'(resp_writeback_o), 32'(cm_wb));
                chk("resp_loadstore", 32'(resp_loadstore_o), 32'(cm_ls));
                chk("resp_id", 32'(resp_id_o), 32'(cm_id));
            end else begin
                chk("commit_idle", 32'(commit_valid_o), 32'd0);
                chk("resp_idle", 32'(resp_valid_o), 32'd0);
            end
            if (exp_iv && q.size() != 0) begin
                chk("issue_instr", issue_instr_o, q[0].i);
                chk("issue_rs0", issue_rs0_o, q[0].a);
                chk("issue_rs1", issue_rs1_o, q[0].b);
                chk("issue_id", 32'(issue_id_o), 32'(exp_id));
            end
            hs = exp_iv && issue_ready_i;
            if (hs) begin
                cm_id = exp_id;
                cm_acc = issue_accept_i;
                cm_wb = issue_writeback_i;
                cm_ls = issue_loadstore_i;
                cm_kill = !issue_accept_i || clear_i;
                void'(q.pop_front());
                exp_id++;
            end
            cm_pend = hs;
            if (clear_i) q.delete();
            else if (instr_valid_i && !full_now) q.push_back('{instr_i, rs0_i, rs1_i});
            exp_iv = exp_iv ? (!hs && !clear_i) : (q.size() != 0);
        end
    end
    initial begin
        int idx, nis, cyc;
        bit took;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_commit_valid", 32'(commit_valid_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_issue_id", 32'(issue_id_o), 32'd0);
        rst_i = 0;
        // single accept
        issue_ready_i = 1;
        issue_accept_i = 1;
        issue_writeback_i = 1;
        push(32'h0000_100B, 32'h1000, 32'h0);
        chk("t1_issue_valid", 32'(issue_valid_o), 32'd1);
        chk("t1_issue_id", 32'(issue_id_o), 32'd0);
        chk("t1_issue_instr", issue_instr_o, 32'h0000_100B);
        tick();
        chk("t1_commit_valid", 32'(commit_valid_o), 32'd1);
        chk("t1_commit_id", 32'(commit_id_o), 32'd0);
        chk("t1_commit_kill", 32'(commit_kill_o), 32'd0);
        chk("t1_resp_valid", 32'(resp_valid_o), 32'd1);
        chk("t1_resp_accept", 32'(resp_accept_o), 32'd1);
        chk("t1_resp_wb", 32'(resp_writeback_o), 32'd1);
        tick();
        chk("t1_idle_valid", 32'(issue_valid_o), 32'd0);
        chk("t1_resp_hold", 32'(resp_accept_o), 32'd1);
        // reject
        do_reset();
        issue_accept_i = 0;
        issue_writeback_i = 0;
        push(32'h0000_200B, 32'h1, 32'h2);
        tick();
        chk("rej_commit_valid", 32'(commit_valid_o), 32'd1);
        chk("rej_commit_kill", 32'(commit_kill_o), 32'd1);
        chk("rej_commit_id", 32'(commit_id_o), 32'd0);
        chk("rej_resp_accept", 32'(resp_accept_o), 32'd0);
        issue_accept_i = 1;
        push(32'h0000_210B, 32'h3, 32'h4);
        chk("rej_next_id", 32'(issue_id_o), 32'd1);
        repeat (2) tick();
        // backpressure
        issue_ready_i = 0;
        push(32'h0000_300B, 32'h3000, 32'h3001);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(issue_valid_o), 32'd1);
            chk("bp_instr", issue_instr_o, 32'h0000_300B);
            chk("bp_rs0", issue_rs0_o, 32'h3000);
            chk("bp_id", 32'(issue_id_o), 32'd2);
            tick();
        end
        issue_ready_i = 1;
        chk("bp_valid6", 32'(issue_valid_o), 32'd1);
        tick();
        chk("bp_commit", 32'(commit_valid_o), 32'd1);
        chk("bp_commit_id", 32'(commit_id_o), 32'd2);
        tick();
        // FIFO full and ID wrap
        do_reset();
        issue_accept_i = 1;
        idx = 0;
        nis = 0;
        cyc = 0;
        while (nis < 17 && cyc < 400) begin
            issue_ready_i = cyc >= 6;
            instr_valid_i = idx < 17;
            instr_i = 32'hA000 + 32'(idx);
            rs0_i = 32'(idx);
            rs1_i = ~32'(idx);
            if (cyc == 4) chk("full_ready", 32'(instr_ready_o), 32'd0);
            if (cyc == 6) chk("full_block", 32'(idx), 32'd4);
            if (issue_valid_o && issue_ready_i) begin
                chk("wrap_id", 32'(issue_id_o), 32'(nis % 16));
                chk("wrap_order", issue_instr_o, 32'hA000 + 32'(nis));
                nis++;
            end
            took = instr_valid_i && instr_ready_o;
            tick();
            if (took) idx++;
            cyc++;
        end
        instr_valid_i = 0;
        chk("wrap_done", 32'(nis), 32'd17);
        repeat (3) tick();
        // flush with a handshake in the same cycle
        do_reset();
        issue_ready_i = 0;
        push(32'hB1, 32'h1, 32'h1);
        push(32'hB2, 32'h2, 32'h2);
        push(32'hB3, 32'h3, 32'h3);
        issue_ready_i = 1;
        clear_i = 1;
        tick();
        clear_i = 0;
        chk("flush_commit", 32'(commit_valid_o), 32'd1);
        chk("flush_kill", 32'(commit_kill_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("flush_no_issue", 32'(issue_valid_o), 32'd0);
            chk("flush_ready", 32'(instr_ready_o), 32'd1);
        end
        // asynchronous reset mid-issue
        issue_ready_i = 0;
        push(32'hC1, 32'h5, 32'h6);
        chk("ar_valid_before", 32'(issue_valid_o), 32'd1);
        #2 rst_i = 1;
        #1;
        chk("ar_valid", 32'(issue_valid_o), 32'd0);
        chk("ar_ready", 32'(instr_ready_o), 32'd1);
        tick();
        rst_i = 0;
        push(32'hC2, 32'h7, 32'h8);
        chk("ar_next_id", 32'(issue_id_o), 32'd0);
        issue_ready_i = 1;
        repeat (2) tick();
        // random traffic
        for (int k = 0; k < 600; k++) begin
            instr_valid_i = $urandom_range(0, 2) != 0;
            instr_i = $urandom;
            rs0_i = $urandom;
            rs1_i = $urandom;
            issue_ready_i = $urandom_range(0, 3) != 0;
            issue_accept_i = $urandom_range(0, 3) != 0;
            issue_writeback_i = 1'($urandom);
            issue_loadstore_i = 1'($urandom);
            clear_i = $urandom_range(0, 39) == 0;
            tick();
        end
        instr_valid_i = 0;
        clear_i = 0;
        issue_ready_i = 1;
        repeat (12) tick();
        chk("drain_idle", 32'(issue_valid_o), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
